// File: rtl/pio_led_panel_pkg.sv
// Shared register map for the LED panel controller and its blink timer.
package pio_led_panel_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_SET      = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CLEAR    = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_TOGGLE   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd6;

endpackage

// File: rtl/led_blink_timer.sv
// Free-running half-period timer producing the shared blink phase.
module led_blink_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                phase
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [PERIOD_W-1:0] limit;
    logic                wrap;

    // A zero period is treated as one, so the phase flips every cycle.
    assign limit = (period == '0) ? '0 : period - 1'b1;
    assign wrap  = (cnt_q >= limit);

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (wrap) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/pio_led_panel_ctrl.sv
// Avalon-MM LED panel controller: writable data, atomic set/clear/toggle,
// per-bit blinking and full readback.
module pio_led_panel_ctrl
    import pio_led_panel_pkg::*;
#(
    parameter int                  WIDTH          = 21,
    parameter logic [WIDTH-1:0]    RESET_VALUE    = 21'h10000,
    parameter int                  PERIOD_W       = 24,
    parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = 24'd5_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    logic                wr;
    logic [WIDTH-1:0]    wdata;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    blink_en_q, blink_en_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_wr;
    logic                phase;

    assign wr    = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];

    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        period_d   = period_q;
        period_wr  = 1'b0;
        if (wr) begin
            case (address)
                ADDR_DATA:     data_d     = wdata;
                ADDR_BLINK_EN: blink_en_d = wdata;
                ADDR_SET:      data_d     = data_q | wdata;
                ADDR_CLEAR:    data_d     = data_q & ~wdata;
                ADDR_TOGGLE:   data_d     = data_q ^ wdata;
                ADDR_PERIOD: begin
                    period_d  = writedata[PERIOD_W-1:0];
                    period_wr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
            period_q   <= DEFAULT_PERIOD;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
        end
    end

    // Restart is taken from the write strobe so the new period starts with LEDs on.
    led_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_q),
        .restart (period_wr),
        .phase   (phase)
    );

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA,
            ADDR_SET,
            ADDR_CLEAR,
            ADDR_TOGGLE:   readdata[WIDTH-1:0]    = data_q;
            ADDR_BLINK_EN: readdata[WIDTH-1:0]    = blink_en_q;
            ADDR_PERIOD:   readdata[PERIOD_W-1:0] = period_q;
            ADDR_STATUS:   readdata[0]            = phase;
            default: ;
        endcase
    end

    assign out_port = data_q & (~blink_en_q | {WIDTH{phase}});

endmodule
